// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner, single-outstanding fetch, FETCH_DEPTH queue.
// Define IFU_STATS_EN to add the fetch_cnt / flush_cnt counter ports.
module instr_fetch_unit #(
    parameter int            AW          = 32,
    parameter int            IM_AW       = 12,
    parameter int            FETCH_DEPTH = 4,
    parameter logic [AW-1:0] RESET_PC    = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    output logic             im_req,
    output logic [IM_AW-1:0] im_addr,
    input  logic             im_rvalid,
    input  logic [31:0]      im_rdata,
    output logic             ir_valid,
    input  logic             ir_ready,
    output logic [31:0]      IR_out,
    output logic [AW-1:0]    PC_out,
    output logic [31:0]      SE_16,
    input  logic             pc_ld,
    input  logic [1:0]       pc_sel,
`ifdef IFU_STATS_EN
    input  logic [AW-1:0]    PC_in,
    output logic [31:0]      fetch_cnt,
    output logic [31:0]      flush_cnt
`else
    input  logic [AW-1:0]    PC_in
`endif
);

    localparam int PW = $clog2(FETCH_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(FETCH_DEPTH);

    typedef enum logic [1:0] { IDLE, WAIT, DROP } state_t;

    state_t        state;
    logic          run_en;
    logic [AW-1:0] pc;
    logic [AW-1:0] req_pc;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] rptr_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [31:0]   ir_mem [FETCH_DEPTH];
    logic [AW-1:0] pc_mem [FETCH_DEPTH];

    logic          push;
    logic          pop;
    logic          flush;
    logic          space;
    logic [AW-1:0] pc4;
    logic [AW-1:0] se_aw;
    logic [AW-1:0] target;
    logic          unused_pc_in;

    assign im_addr      = pc[IM_AW-1:0];
    assign SE_16        = {{16{IR_out[15]}}, IR_out[15:0]};
    assign unused_pc_in = ^PC_in[1:0];

    // Redirect targets, queue strobes and request issue
    always_comb begin
        pc4    = PC_out + AW'(4);
        se_aw  = {{(AW-16){IR_out[15]}}, IR_out[15:0]};
        target = '0;
        unique case (1'b1)
            pc_sel == 2'h2: target = {PC_in[AW-1:2], 2'b00};
            pc_sel == 2'h1: target = ((pc4 >> 28) << 28)
                                   | AW'({IR_out[25:0], 2'b00});
            default:        target = pc4 + (se_aw << 2);
        endcase
        flush = pc_ld && (pc_sel == 2'h2 || ir_valid);
        push  = (state == WAIT) && im_rvalid && !flush;
        pop   = ir_valid && ir_ready && !flush;
        space = 1'b0;
        if (state == IDLE)
            space = count < DEPTH;
        else if (state == WAIT)
            space = im_rvalid && (count + CW'(1) < DEPTH);
        im_req    = run_en && !flush && space;
        rptr_nxt  = pop ? rptr + PW'(1) : rptr;
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Fetch FSM and program counter
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
            run_en <= 1'b0;
        end else begin
            run_en <= 1'b1;
            if (im_req) begin
                pc     <= pc + AW'(4);
                req_pc <= pc;
            end
            if (flush) begin
                pc    <= target;
                state <= (state != IDLE && !im_rvalid) ? DROP : IDLE;
            end else begin
                unique case (state)
                    IDLE:    if (im_req) state <= WAIT;
                    WAIT:    if (im_rvalid) state <= im_req ? WAIT : IDLE;
                    DROP:    if (im_rvalid) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Queue pointers and registered head (holds its value while empty)
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            ir_valid <= 1'b0;
            IR_out   <= '0;
            PC_out   <= '0;
        end else if (flush) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            ir_valid <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + PW'(1);
            rptr     <= rptr_nxt;
            count    <= count_nxt;
            ir_valid <= count_nxt != '0;
            if (push && count == CW'(pop)) begin
                IR_out <= im_rdata;
                PC_out <= req_pc;
            end else if (count_nxt != '0) begin
                IR_out <= ir_mem[rptr_nxt];
                PC_out <= pc_mem[rptr_nxt];
            end
        end
    end

    // Queue storage, written on push
    always_ff @(posedge CLK) begin
        if (push) begin
            ir_mem[wptr] <= im_rdata;
            pc_mem[wptr] <= req_pc;
        end
    end

`ifdef IFU_STATS_EN
    // Pushed-word and accepted-redirect counters
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (push)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (flush)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule
